multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle sequencing controller for the MIPS-subset datapath (lw, sw, R-type, addi, beq, j). It replaces single-cycle decoding with a registered FSM that steps one instruction through fetch, decode, execute, memory and writeback. Each step drives the shared ALU, memory port, register file and PC enables. It also waits on a memory-ready handshake and aborts stalled data accesses after a bounded wait.

## Interface
- WAIT_LIMIT, 15: max consecutive not-ready cycles tolerated in MEMRD/MEMWR before abort (1..255).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction[31:26] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWE  out  1  PC write enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result register.
- IRWE  out  1  instruction register write enable.
- MtoRFSel  out  1  register file write data: 1 = memory data register, 0 = ALU result register.
- RFDSel  out  1  register file destination: 1 = rd, 0 = rt.
- RFWE  out  1  register file write enable.
- DMWE  out  1  data memory write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B input: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSrc  out  2  00 = ALU result, 01 = ALU result register (branch target), 10 = jump target.
- state  out  4  current state encoding (debug).
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  one-cycle pulse when decode sees an unsupported opcode.
- mem_err  out  1  one-cycle pulse when a data access times out.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and recover to FETCH on the next edge.
- Outputs are Moore decodes of `state`, except where noted. Every output not listed for a state is 0.
- FETCH: ALUSrcB=01. IRWE and PCWE equal mem_ready. If mem_ready, go to DECODE; else stay in FETCH with no timeout.
- DECODE: ALUSrcB=11 (precompute branch target). Next state by opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 001000 -> ADDIEX
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> FETCH, with illegal=1 this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10. Goes to MEMRD if opcode=100011, else MEMWR.
- MEMRD: IorD=1. If mem_ready, go to MEMWB.
- MEMWB: MtoRFSel=1, RFWE=1, retire=1; go to FETCH.
- MEMWR: IorD=1, DMWE=1. If mem_ready, retire=1 and go to FETCH.
- EXEC: ALUSrcA=1, ALUOp=10; go to ALUWB. ALUWB: RFDSel=1, RFWE=1, retire=1; go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10; go to ADDIWB. ADDIWB: RFWE=1, retire=1; go to FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, PCWE=zero (Mealy), retire=1; go to FETCH.
- JUMP: PCSrc=10, PCWE=1, retire=1; go to FETCH.
- Wait counter (8-bit):
  - cleared on entry to MEMRD/MEMWR and whenever mem_ready=1; increments each cycle in MEMRD/MEMWR with mem_ready=0.
  - When it reaches WAIT_LIMIT with mem_ready=0: go to FETCH, mem_err=1, retire=0, no RFWE follows.
  - DMWE stays asserted during that final abort cycle. The memory must ignore DMWE without mem_ready.
- mem_ready and a timeout in the same cycle: mem_ready wins and the access completes normally.

## Timing
- Reset: while rst_n=0, state=FETCH and the wait counter is 0. PCWE, IRWE, RFWE, DMWE, retire, illegal and mem_err are forced to 0. After release, the first IRWE/PCWE pulse can occur in the first cycle with mem_ready=1.
- Reset mid-instruction aborts immediately; no partial write is issued after rst_n falls.
- Cycles per instruction with mem_ready always 1, FETCH through retire: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal opcode 2.
- Each not-ready cycle in FETCH, MEMRD or MEMWR adds one cycle.
- The state register updates on the rising edge of clk. Outputs are valid combinationally within the same cycle.

## Test plan
- Reset then lw (opcode 100011), mem_ready=1: states 0,1,2,3,4,0. RFWE=1 and MtoRFSel=1 only in state 4; retire pulses once; 5 cycles total.
- sw with mem_ready low for 3 cycles in MEMWR: DMWE held high 4 cycles; retire in the cycle mem_ready=1; RFWE never asserted.
- beq with zero=1, then zero=0: PCWE=1 and PCSrc=01 in BRANCH for the first; PCWE=0 for the second; both take 3 cycles.
- Opcode 111111: illegal pulses in DECODE, next state is FETCH, no enables asserted.
- lw with WAIT_LIMIT=4 and mem_ready held low in MEMRD: after 4 not-ready cycles state goes to FETCH, mem_err=1 for one cycle, no RFWE. Also check mem_ready rising exactly at the limit cycle completes the load normally.
- rst_n asserted in ALUWB and in MEMWR: RFWE and DMWE drop asynchronously, state becomes 0, and execution resumes cleanly after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing controller for the MIPS-subset datapath.
// Steps one instruction through fetch/decode/execute/memory/writeback.
module multicycle_ctrl #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWE,
   output logic       IorD,
   output logic       IRWE,
   output logic       MtoRFSel,
   output logic       RFDSel,
   output logic       RFWE,
   output logic       DMWE,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic [3:0] state,
   output logic       retire,
   output logic       illegal,
   output logic       mem_err
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [7:0] LIM = 8'(WAIT_LIMIT);

   state_t     st_q, st_d;
   logic [7:0] cnt_q, cnt_d;
   logic       timeout;

   logic pcwe, irwe, rfwe, dmwe;
   logic ret, ill, err;

   // this cycle would be the WAIT_LIMIT-th consecutive not-ready cycle
   assign timeout = !mem_ready && (cnt_q == LIM - 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= S_FETCH;
         cnt_q <= 8'd0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      st_d     = S_FETCH;
      cnt_d    = 8'd0;
      pcwe     = 1'b0;
      irwe     = 1'b0;
      rfwe     = 1'b0;
      dmwe     = 1'b0;
      ret      = 1'b0;
      ill      = 1'b0;
      err      = 1'b0;
      IorD     = 1'b0;
      MtoRFSel = 1'b0;
      RFDSel   = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
      unique case (st_q)
         S_FETCH: begin
            ALUSrcB = 2'b01;
            irwe    = mem_ready;
            pcwe    = mem_ready;
            st_d    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_LW,
               OP_SW:   st_d = S_MEMADR;
               OP_R:    st_d = S_EXEC;
               OP_ADDI: st_d = S_ADDIEX;
               OP_BEQ:  st_d = S_BRANCH;
               OP_J:    st_d = S_JUMP;
               default: begin
                  st_d = S_FETCH;
                  ill  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            st_d    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            IorD = 1'b1;
            if (mem_ready) begin
               st_d = S_MEMWB;
            end else if (timeout) begin
               st_d = S_FETCH;
               err  = 1'b1;
            end else begin
               st_d  = S_MEMRD;
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_MEMWB: begin
            MtoRFSel = 1'b1;
            rfwe     = 1'b1;
            ret      = 1'b1;
         end
         S_MEMWR: begin
            // DMWE held through an abort; memory qualifies it with mem_ready
            IorD = 1'b1;
            dmwe = 1'b1;
            if (mem_ready) begin
               ret = 1'b1;
            end else if (timeout) begin
               err = 1'b1;
            end else begin
               st_d  = S_MEMWR;
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            st_d    = S_ALUWB;
         end
         S_ALUWB: begin
            RFDSel = 1'b1;
            rfwe   = 1'b1;
            ret    = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 2'b01;
            pcwe    = zero;
            ret     = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            st_d    = S_ADDIWB;
         end
         S_ADDIWB: begin
            rfwe = 1'b1;
            ret  = 1'b1;
         end
         S_JUMP: begin
            PCSrc = 2'b10;
            pcwe  = 1'b1;
            ret   = 1'b1;
         end
         default: st_d = S_FETCH;
      endcase
   end

   // enables and pulses are squashed the moment reset falls
   assign PCWE    = pcwe & rst_n;
   assign IRWE    = irwe & rst_n;
   assign RFWE    = rfwe & rst_n;
   assign DMWE    = dmwe & rst_n;
   assign retire  = ret & rst_n;
   assign illegal = ill & rst_n;
   assign mem_err = err & rst_n;
   assign state   = st_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: vector table, random instruction
// stream against an instruction-level model, reset corner cases.
module tb_multicycle_ctrl;

   localparam int WL = 4;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       PCWE, IorD, IRWE, MtoRFSel, RFDSel, RFWE, DMWE, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic [3:0] state;
   logic       retire, illegal, mem_err;
   logic [16:0] act;

   int n_tests = 0;
   int n_fail = 0;

   multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .PCWE(PCWE), .IorD(IorD), .IRWE(IRWE),
      .MtoRFSel(MtoRFSel), .RFDSel(RFDSel), .RFWE(RFWE), .DMWE(DMWE),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSrc(PCSrc), .state(state), .retire(retire),
      .illegal(illegal), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   assign act = {PCWE, IorD, IRWE, MtoRFSel, RFDSel, RFWE, DMWE,
                 ALUSrcA, ALUSrcB, ALUOp, PCSrc, retire, illegal,
                 mem_err};

   typedef struct {
      logic [5:0] op;
      logic       z;
      logic       mr;
      logic [3:0] st;
      logic       to;
   } cyc_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      int         fw;
      int         dw;
      int         ret;
      int         err;
   } vec_t;

   cyc_t q[$];
   vec_t tv[12];

   function automatic logic legal(input logic [5:0] op);
      return op == OP_LW || op == OP_SW || op == OP_R ||
             op == OP_ADDI || op == OP_BEQ || op == OP_J;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // output table by state name, straight from the behaviour rules
   function automatic logic [16:0] expo(input cyc_t c);
      logic pcwe, iord, irwe, m2r, rfd, rfwe, dmwe, asa;
      logic ret, ill, err;
      logic [1:0] asb, aop, pcs;
      {pcwe, iord, irwe, m2r, rfd, rfwe, dmwe, asa} = 8'd0;
      {ret, ill, err} = 3'd0;
      {asb, aop, pcs} = 6'd0;
      case (c.st)
         4'd0: begin asb = 2'b01; irwe = c.mr; pcwe = c.mr; end
         4'd1: begin asb = 2'b11; ill = !legal(c.op); end
         4'd2: begin asa = 1'b1; asb = 2'b10; end
         4'd3: begin iord = 1'b1; err = c.to; end
         4'd4: begin m2r = 1'b1; rfwe = 1'b1; ret = 1'b1; end
         4'd5: begin
            iord = 1'b1; dmwe = 1'b1; ret = c.mr; err = c.to;
         end
         4'd6: begin asa = 1'b1; aop = 2'b10; end
         4'd7: begin rfd = 1'b1; rfwe = 1'b1; ret = 1'b1; end
         4'd8: begin
            asa = 1'b1; aop = 2'b01; pcs = 2'b01;
            pcwe = c.z; ret = 1'b1;
         end
         4'd9: begin asa = 1'b1; asb = 2'b10; end
         4'd10: begin rfwe = 1'b1; ret = 1'b1; end
         4'd11: begin pcs = 2'b10; pcwe = 1'b1; ret = 1'b1; end
         default: ;
      endcase
      return {pcwe, iord, irwe, m2r, rfd, rfwe, dmwe, asa,
              asb, aop, pcs, ret, ill, err};
   endfunction

   task automatic push(input logic [3:0] st, input logic [5:0] op,
                       input logic z, input logic mr, input logic to);
      cyc_t c;
      c.op = op; c.z = z; c.mr = mr; c.st = st; c.to = to;
      q.push_back(c);
   endtask

   task automatic mem_phase(input logic [3:0] st, input logic [5:0] op,
                            input int dw, output logic aborted);
      aborted = (dw >= WL);
      if (aborted) begin
         for (int i = 0; i < WL - 1; i++) push(st, op, rb(), 1'b0, 1'b0);
         push(st, op, rb(), 1'b0, 1'b1);
      end else begin
         for (int i = 0; i < dw; i++) push(st, op, rb(), 1'b0, 1'b0);
         push(st, op, rb(), 1'b1, 1'b0);
      end
   endtask

   // expected per-cycle trace of one instruction
   task automatic gen(input logic [5:0] op, input logic z,
                      input int fw, input int dw);
      logic ab;
      for (int i = 0; i < fw; i++) push(4'd0, op, rb(), 1'b0, 1'b0);
      push(4'd0, op, rb(), 1'b1, 1'b0);
      push(4'd1, op, rb(), rb(), 1'b0);
      if (op == OP_LW) begin
         push(4'd2, op, rb(), rb(), 1'b0);
         mem_phase(4'd3, op, dw, ab);
         if (!ab) push(4'd4, op, rb(), rb(), 1'b0);
      end else if (op == OP_SW) begin
         push(4'd2, op, rb(), rb(), 1'b0);
         mem_phase(4'd5, op, dw, ab);
      end else if (op == OP_R) begin
         push(4'd6, op, rb(), rb(), 1'b0);
         push(4'd7, op, rb(), rb(), 1'b0);
      end else if (op == OP_ADDI) begin
         push(4'd9, op, rb(), rb(), 1'b0);
         push(4'd10, op, rb(), rb(), 1'b0);
      end else if (op == OP_BEQ) begin
         push(4'd8, op, z, rb(), 1'b0);
      end else if (op == OP_J) begin
         push(4'd11, op, rb(), rb(), 1'b0);
      end
   endtask

   task automatic run(input int stop, output int rets, output int errs);
      cyc_t c;
      logic [20:0] got, need;
      rets = 0;
      errs = 0;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk);
         #1;
         opcode = c.op;
         zero = c.z;
         mem_ready = c.mr;
         @(negedge clk);
         got = {state, act};
         need = {c.st, expo(c)};
         n_tests++;
         if (got !== need) begin
            n_fail++;
            $display("FAIL cycle op=%b: state=%0d outs=%b, need state=%0d outs=%b",
                     c.op, state, act, c.st, expo(c));
         end
         if (retire === 1'b1) rets++;
         if (mem_err === 1'b1) errs++;
         if (stop >= 0 && int'(c.st) == stop) return;
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      n_tests++;
      if (state !== 4'd0) begin
         n_fail++;
         $display("FAIL end_state: state=%0d, need 0", state);
      end
   endtask

   task automatic check_cnt(input string name, input int got,
                            input int need);
      n_tests++;
      if (got != need) begin
         n_fail++;
         $display("FAIL %s: got %0d, need %0d", name, got, need);
      end
   endtask

   task automatic reset_mid(input logic [5:0] op, input int dw,
                            input int at, input string name);
      int r, e;
      gen(op, 1'b0, 0, dw);
      run(at, r, e);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (RFWE !== 1'b0 || DMWE !== 1'b0 || state !== 4'd0) begin
         n_fail++;
         $display("FAIL %s: RFWE=%b DMWE=%b state=%0d, need 0 0 0",
                  name, RFWE, DMWE, state);
      end
      q.delete();
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      gen(OP_ADDI, 1'b0, 1, 0);
      run(-1, r, e);
      check_cnt({name, "_resume"}, r, 1);
   endtask

   initial begin
      int r, e, k;
      logic [5:0] op;

      tv[0]  = '{OP_LW,      1'b0, 0, 0, 1, 0};
      tv[1]  = '{OP_SW,      1'b0, 0, 3, 1, 0};
      tv[2]  = '{OP_R,       1'b0, 1, 0, 1, 0};
      tv[3]  = '{OP_ADDI,    1'b1, 0, 0, 1, 0};
      tv[4]  = '{OP_BEQ,     1'b1, 0, 0, 1, 0};
      tv[5]  = '{OP_BEQ,     1'b0, 2, 0, 1, 0};
      tv[6]  = '{OP_J,       1'b0, 0, 0, 1, 0};
      tv[7]  = '{6'b111111,  1'b0, 0, 0, 0, 0};
      tv[8]  = '{OP_LW,      1'b0, 0, 4, 0, 1};
      tv[9]  = '{OP_LW,      1'b0, 0, 3, 1, 0};
      tv[10] = '{OP_SW,      1'b0, 0, 4, 0, 1};
      tv[11] = '{OP_SW,      1'b0, 1, 9, 0, 1};

      mem_ready = 1'b1;
      opcode = OP_LW;
      #12;
      n_tests++;
      if (state !== 4'd0 || PCWE !== 1'b0 || IRWE !== 1'b0 ||
          RFWE !== 1'b0 || DMWE !== 1'b0 || retire !== 1'b0 ||
          illegal !== 1'b0 || mem_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: state=%0d outs=%b, need state=0 enables 0",
                  state, act);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         gen(tv[i].op, tv[i].z, tv[i].fw, tv[i].dw);
         run(-1, r, e);
         check_cnt($sformatf("vec%0d_retire", i), r, tv[i].ret);
         check_cnt($sformatf("vec%0d_mem_err", i), e, tv[i].err);
      end

      reset_mid(OP_R, 0, 7, "rst_aluwb");
      reset_mid(OP_SW, 3, 5, "rst_memwr");

      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 6);
         case (k)
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_R;
            3: op = OP_ADDI;
            4: op = OP_BEQ;
            5: op = OP_J;
            default: op = 6'($urandom);
         endcase
         gen(op, rb(), $urandom_range(0, 2), $urandom_range(0, 6));
         run(-1, r, e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
